// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, state encoding and two's-complement helper for the divide sequencer
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef logic [1:0] div_state_t;

    localparam div_state_t ST_IDLE   = 2'd0;
    localparam div_state_t ST_LAUNCH = 2'd1;
    localparam div_state_t ST_WAIT   = 2'd2;
    localparam div_state_t ST_DONE   = 2'd3;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] x);
        return ~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - operand magnitudes and conditional quotient negate for signed divides
module div_sign_fix
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] op_a,
    input  logic [DIV_WIDTH-1:0] op_b,
    input  logic                 op_signed,
    input  logic [DIV_WIDTH-1:0] q_in,
    input  logic                 q_neg,
    output logic [DIV_WIDTH-1:0] mag_a,
    output logic [DIV_WIDTH-1:0] mag_b,
    output logic [DIV_WIDTH-1:0] q_out
);

    // |0x8000_0000| stays 0x8000_0000, which the core treats as a plain unsigned value
    assign mag_a = (op_signed && op_a[DIV_WIDTH-1]) ? twos_neg(op_a) : op_a;
    assign mag_b = (op_signed && op_b[DIV_WIDTH-1]) ? twos_neg(op_b) : op_b;
    assign q_out = q_neg ? twos_neg(q_in) : q_in;

endmodule

// File: rtl/divide_sequencer.sv
// rtl/divide_sequencer.sv - request/response front end for the iterative divider core
// Optional signed support is built when SIGNED_DIV_EN is defined.
module divide_sequencer
    import div_pkg::*;
#(
    parameter int DIV_LATENCY = 33
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_q,
    output logic        rsp_dz,
    output logic        div_clr,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_q
);

    div_state_t            state;
    logic [5:0]            cnt;
    logic [DIV_WIDTH-1:0]  mag_a;
    logic [DIV_WIDTH-1:0]  mag_b;
    logic [DIV_WIDTH-1:0]  q_fixed;

`ifdef SIGNED_DIV_EN
    logic sign_a;
    logic sign_b;
    logic op_signed;
    logic q_neg;

    assign q_neg = op_signed && (sign_a != sign_b);

    div_sign_fix u_sign_fix (
        .op_a      (req_a),
        .op_b      (req_b),
        .op_signed (req_signed),
        .q_in      (div_q),
        .q_neg     (q_neg),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .q_out     (q_fixed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            op_signed <= 1'b0;
        end else if (state == ST_IDLE && req_valid) begin
            sign_a    <= req_a[DIV_WIDTH-1];
            sign_b    <= req_b[DIV_WIDTH-1];
            op_signed <= req_signed;
        end
    end
`else
    logic unused_req_signed;

    assign unused_req_signed = req_signed;
    assign mag_a             = req_a;
    assign mag_b             = req_b;
    assign q_fixed           = div_q;
`endif

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign div_clr   = (state != ST_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= 6'd0;
            rsp_q  <= '0;
            rsp_dz <= 1'b0;
            div_a  <= '0;
            div_b  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Zero divisor never runs the core; the result is known immediately
                        if (req_b == '0) begin
                            rsp_q  <= DIV_ZERO_Q;
                            rsp_dz <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            div_a <= mag_a;
                            div_b <= mag_b;
                            state <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= 6'd0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(DIV_LATENCY - 1)) begin
                        rsp_q  <= q_fixed;
                        rsp_dz <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// tb/tb_divide_sequencer.sv - self-checking bench for divide_sequencer with a behavioural divider core
module tb_divide_sequencer;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_q;
    logic        rsp_dz;
    logic        div_clr;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_q;

    int n_run = 0;
    int n_fail = 0;
    int clr_cnt = 0;
    int clr_low_cycles = 0;
    logic [32:0] exp_q[$];

    divide_sequencer #(.DIV_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_dz     (rsp_dz),
        .div_clr    (div_clr),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q)
    );

    always #5 clk = ~clk;

    // Core model: quotient becomes valid only after LAT cycles with div_clr low
    always @(posedge clk) clr_cnt <= div_clr ? 0 : clr_cnt + 1;
    assign div_q = (clr_cnt >= LAT - 1 && div_b != 32'd0) ? div_a / div_b : 32'hDEAD_BEEF;

    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        longint sq;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF};
`ifdef SIGNED_DIV_EN
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            sq = sa / sb;
            return {1'b0, sq[31:0]};
        end
`else
        begin
            logic unused_s;
            unused_s = s;
        end
`endif
        sa = longint'(a);
        sb = longint'(b);
        sq = sa / sb;
        return {1'b0, sq[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (req_valid && req_ready) exp_q.push_back(ref_div(req_a, req_b, req_signed));
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (!div_clr) clr_low_cycles++;
            check("req_ready_busy", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    check("rsp_q", rsp_q, exp_q[0][31:0]);
                    check("rsp_dz", {31'd0, rsp_dz}, {31'd0, exp_q[0][32]});
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                          output logic [31:0] q, output logic dz);
        int lat;
        int guard;
        logic [32:0] r;
        r = ref_div(a, b, s);
        @(negedge clk);
        req_a = a;
        req_b = b;
        req_signed = s;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, r[32] ? 0 : LAT + 1);
        q = rsp_q;
        dz = rsp_dz;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic        dz;
        logic [32:0] r;
        logic [31:0] q0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          low0;
        int          guard;

        reset = 1'b0;
        req_valid = 1'b0;
        req_a = 32'd0;
        req_b = 32'd0;
        req_signed = 1'b0;
        rsp_ready = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_q", rsp_q, 32'd0);
        check("rst_rsp_dz", {31'd0, rsp_dz}, 32'd0);
        check("rst_div_clr", {31'd0, div_clr}, 32'd1);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);

        r = ref_div(32'd100, 32'd7, 1'b0);
        check("model_100_7", r[31:0], 32'd14);
        r = ref_div(32'd5, 32'd0, 1'b0);
        check("model_dz_q", r[31:0], 32'hFFFF_FFFF);
        check("model_dz_flag", {31'd0, r[32]}, 32'd1);

        repeat (3) @(negedge clk);
        reset = 1'b1;

        low0 = clr_low_cycles;
        do_req(32'd100, 32'd7, 1'b0, 0, q, dz);
        check("u100_7_q", q, 32'd14);
        check("u100_7_dz", {31'd0, dz}, 32'd0);
        check("u100_7_clr_low", clr_low_cycles - low0, LAT);

`ifdef SIGNED_DIV_EN
        do_req(32'hFFFF_FF9C, 32'd7, 1'b1, 1, q, dz);
        check("s_m100_7_q", q, 32'hFFFF_FFF2);
        do_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, q, dz);
        check("s_min_m1_q", q, 32'h8000_0000);
        check("s_min_m1_dz", {31'd0, dz}, 32'd0);
`endif

        low0 = clr_low_cycles;
        do_req(32'd5, 32'd0, 1'b0, 2, q, dz);
        check("dz_q", q, 32'hFFFF_FFFF);
        check("dz_flag", {31'd0, dz}, 32'd1);
        check("dz_clr_stays_high", clr_low_cycles - low0, 0);

        // Backpressure with a competing request held on the input
        @(negedge clk);
        req_a = 32'd1000;
        req_b = 32'd10;
        req_signed = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_a = 32'd77;
        req_b = 32'd1;
        guard = 0;
        while (!rsp_valid && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        q0 = rsp_q;
        check("bp_first_q", q0, 32'd100);
        repeat (10) begin
            @(negedge clk);
            check("bp_q_stable", rsp_q, q0);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset in WAIT with the latency counter at 10
        @(negedge clk);
        req_a = 32'd9000;
        req_b = 32'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_div_clr", {31'd0, div_clr}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_div_clr", {31'd0, div_clr}, 32'd1);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        do_req(32'd9, 32'd3, 1'b0, 0, q, dz);
        check("post_rst_9_3", q, 32'd3);

        do_req(32'hFFFF_FFFE, 32'd2, 1'b1, 0, q, dz);
`ifdef SIGNED_DIV_EN
        check("sgn_m2_2", q, 32'hFFFF_FFFF);
`else
        check("unsigned_fffe_2", q, 32'h7FFF_FFFF);
`endif

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2, 3: rb = $urandom_range(1, 15);
                4:       rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            r = ref_div(ra, rb, rs);
            do_req(ra, rb, rs, $urandom_range(0, 3), q, dz);
            check("rand_q", q, r[31:0]);
            check("rand_dz", {31'd0, dz}, {31'd0, r[32]});
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
